// File: rtl/iter_alu_if.sv
// Operand/result handshake bundle for the iterative ALU.
// Master drives operands and consumes results; slave is the ALU.
interface iter_alu_if #(
   parameter int WIDTH      = 32,
   parameter int CTRL_WIDTH = 4
);
   logic                  in_valid;
   logic                  in_ready;
   logic [CTRL_WIDTH-1:0] alu_control;
   logic [WIDTH-1:0]      a;
   logic [WIDTH-1:0]      b;
   logic                  out_valid;
   logic                  out_ready;
   logic [WIDTH-1:0]      alu_result;
   logic                  carry;
   logic                  over_flow;
   logic                  zero;
   logic                  illegal;

   modport master (
      output in_valid, alu_control, a, b, out_ready,
      input  in_ready, out_valid, alu_result,
      input  carry, over_flow, zero, illegal
   );

   modport slave (
      input  in_valid, alu_control, a, b, out_ready,
      output in_ready, out_valid, alu_result,
      output carry, over_flow, zero, illegal
   );
endinterface

// File: rtl/iter_alu.sv
// Sequential ALU: single-cycle integer ops plus bit-serial
// unsigned multiply/divide behind valid/ready handshakes.
module iter_alu #(
   parameter int WIDTH      = 32,
   parameter int CTRL_WIDTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   iter_alu_if.slave  bus
);
   localparam int SHW = $clog2(WIDTH);

   localparam logic [CTRL_WIDTH-1:0] OP_ADD   = CTRL_WIDTH'(0);
   localparam logic [CTRL_WIDTH-1:0] OP_SUB   = CTRL_WIDTH'(1);
   localparam logic [CTRL_WIDTH-1:0] OP_AND   = CTRL_WIDTH'(2);
   localparam logic [CTRL_WIDTH-1:0] OP_OR    = CTRL_WIDTH'(3);
   localparam logic [CTRL_WIDTH-1:0] OP_XOR   = CTRL_WIDTH'(4);
   localparam logic [CTRL_WIDTH-1:0] OP_SLT   = CTRL_WIDTH'(5);
   localparam logic [CTRL_WIDTH-1:0] OP_SLL   = CTRL_WIDTH'(6);
   localparam logic [CTRL_WIDTH-1:0] OP_SRL   = CTRL_WIDTH'(7);
   localparam logic [CTRL_WIDTH-1:0] OP_SRA   = CTRL_WIDTH'(8);
   localparam logic [CTRL_WIDTH-1:0] OP_SLTU  = CTRL_WIDTH'(9);
   localparam logic [CTRL_WIDTH-1:0] OP_MUL   = CTRL_WIDTH'(10);
   localparam logic [CTRL_WIDTH-1:0] OP_MULHU = CTRL_WIDTH'(11);
   localparam logic [CTRL_WIDTH-1:0] OP_DIVU  = CTRL_WIDTH'(12);
   localparam logic [CTRL_WIDTH-1:0] OP_REMU  = CTRL_WIDTH'(13);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                st_q, st_d;
   logic [CTRL_WIDTH-1:0] op_q, op_d;
   logic [WIDTH-1:0]      opd_q, opd_d;
   logic [2*WIDTH-1:0]    acc_q, acc_d;
   logic [SHW-1:0]        cnt_q, cnt_d;
   logic [WIDTH-1:0]      res_q, res_d;
   logic                  carry_q, carry_d;
   logic                  ovf_q, ovf_d;
   logic                  zero_q, zero_d;
   logic                  ill_q, ill_d;

   logic [WIDTH-1:0]      sc_res;
   logic                  sc_carry, sc_ovf, sc_ill;
   logic [WIDTH:0]        add_s, sub_s;
   logic [SHW-1:0]        sh;
   logic                  is_iter, is_mul, op_is_div, op_hi;
   logic [WIDTH:0]        msum, dtrial;
   logic [2*WIDTH-1:0]    mstep, dstep, step;
   logic [WIDTH-1:0]      fin_res;

   // Single-cycle datapath works straight off the bus operands.
   always_comb begin
      sh       = bus.b[SHW-1:0];
      add_s    = {1'b0, bus.a} + {1'b0, bus.b};
      sub_s    = {1'b0, bus.a} + {1'b0, ~bus.b} + 1'b1;
      sc_res   = '0;
      sc_carry = 1'b0;
      sc_ovf   = 1'b0;
      sc_ill   = 1'b0;
      case (bus.alu_control)
         OP_ADD: begin
            sc_res   = add_s[WIDTH-1:0];
            sc_carry = add_s[WIDTH];
            sc_ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                       (add_s[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_SUB: begin
            sc_res   = sub_s[WIDTH-1:0];
            sc_carry = sub_s[WIDTH];
            sc_ovf   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                       (sub_s[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_AND:  sc_res = bus.a & bus.b;
         OP_OR:   sc_res = bus.a | bus.b;
         OP_XOR:  sc_res = bus.a ^ bus.b;
         OP_SLT:  sc_res = {{(WIDTH-1){1'b0}},
                            ($signed(bus.a) < $signed(bus.b))};
         OP_SLL:  sc_res = bus.a << sh;
         OP_SRL:  sc_res = bus.a >> sh;
         OP_SRA:  sc_res = WIDTH'($signed(bus.a) >>> sh);
         OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
         default: sc_ill = 1'b1;
      endcase
      is_iter = (bus.alu_control == OP_MUL)  ||
                (bus.alu_control == OP_MULHU) ||
                (bus.alu_control == OP_DIVU) ||
                (bus.alu_control == OP_REMU);
      is_mul  = (bus.alu_control == OP_MUL) ||
                (bus.alu_control == OP_MULHU);
      if (is_iter) sc_ill = 1'b0;
   end

   // acc_q holds {high, low}: product halves or {remainder, quotient}.
   always_comb begin
      op_is_div = (op_q == OP_DIVU) || (op_q == OP_REMU);
      op_hi     = (op_q == OP_MULHU) || (op_q == OP_REMU);
      msum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                  (acc_q[0] ? {1'b0, opd_q} : '0);
      mstep     = {msum, acc_q[WIDTH-1:1]};
      dtrial    = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opd_q};
      if (!dtrial[WIDTH])
         dstep = {dtrial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else
         dstep = {acc_q[2*WIDTH-2:0], 1'b0};
      step      = op_is_div ? dstep : mstep;
      fin_res   = op_hi ? step[2*WIDTH-1:WIDTH] : step[WIDTH-1:0];
   end

   always_comb begin
      st_d    = st_q;
      op_d    = op_q;
      opd_d   = opd_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      ill_d   = ill_q;
      case (st_q)
         IDLE: begin
            if (bus.in_valid) begin
               op_d = bus.alu_control;
               if (is_iter) begin
                  opd_d = is_mul ? bus.a : bus.b;
                  acc_d = is_mul ? {{WIDTH{1'b0}}, bus.b}
                                 : {{WIDTH{1'b0}}, bus.a};
                  cnt_d = SHW'(WIDTH-1);
                  st_d  = BUSY;
               end else begin
                  res_d   = sc_res;
                  carry_d = sc_carry;
                  ovf_d   = sc_ovf;
                  zero_d  = (sc_res == '0);
                  ill_d   = sc_ill;
                  st_d    = DONE;
               end
            end
         end
         BUSY: begin
            acc_d = step;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               cnt_d   = '0;
               res_d   = fin_res;
               carry_d = 1'b0;
               ovf_d   = 1'b0;
               zero_d  = (fin_res == '0);
               ill_d   = 1'b0;
               st_d    = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) st_d = IDLE;
         end
         default: st_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q    <= IDLE;
         op_q    <= '0;
         opd_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         st_q    <= st_d;
         op_q    <= op_d;
         opd_q   <= opd_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
         ill_q   <= ill_d;
      end
   end

   assign bus.in_ready   = (st_q == IDLE) && !rst;
   assign bus.out_valid  = (st_q == DONE);
   assign bus.alu_result = res_q;
   assign bus.carry      = carry_q;
   assign bus.over_flow  = ovf_q;
   assign bus.zero       = zero_q;
   assign bus.illegal    = ill_q;
endmodule

// File: tb/tb_iter_alu.sv
// Scoreboard bench for iter_alu: directed vectors pushed on issue,
// a negedge monitor pops and compares on each result handoff.
module tb_iter_alu;
   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   pass_cnt = 0;
   int   tot_cnt = 0;

   typedef struct {
      logic [35:0] exp;
      int          lat;
      int          acc;
   } sb_t;

   sb_t sb[$];
   sb_t cur;
   bit  seen = 1'b0;

   iter_alu_if #(.WIDTH(32), .CTRL_WIDTH(4)) bus ();

   iter_alu #(.WIDTH(32), .CTRL_WIDTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] req);
      tot_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s: got %h, expected %h", name, act, req);
   endtask

   // Monitor: compares every valid cycle, pops on handoff.
   always @(negedge clk) begin
      if (rst) begin
         seen = 1'b0;
      end else if (bus.out_valid) begin
         if (sb.size() == 0) begin
            tot_cnt++;
            $display("FAIL unexpected_out: got %h, expected none",
                     bus.alu_result);
         end else begin
            cur = sb[0];
            if (!seen) begin
               seen = 1'b1;
               chk("latency", 64'(cyc - cur.acc), 64'(cur.lat));
            end
            chk("result", {28'd0, bus.alu_result, bus.carry,
                           bus.over_flow, bus.zero, bus.illegal},
                {28'd0, cur.exp});
            if (bus.out_ready) begin
               void'(sb.pop_front());
               seen = 1'b0;
            end
         end
      end
   end

   task automatic issue(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] r,
                        input logic c, input logic v, input logic z,
                        input logic il, input int lat, input bit push);
      sb_t e;
      bit  ok = 1'b0;
      bus.alu_control = op;
      bus.a           = a;
      bus.b           = b;
      bus.in_valid    = 1'b1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         tot_cnt++;
         $display("FAIL accept_timeout: got in_ready 0, expected 1");
      end else begin
         e.exp = {r, c, v, z, il};
         e.lat = lat;
         e.acc = cyc;
         if (push) sb.push_back(e);
      end
      @(posedge clk);
      #1;
      bus.in_valid    = 1'b0;
      bus.alu_control = ~op;
      bus.a           = ~a;
      bus.b           = ~b;
   endtask

   initial begin
      bit vseen;
      rst           = 1'b1;
      bus.in_valid  = 1'b1;
      bus.alu_control = 4'd0;
      bus.a         = 32'd1;
      bus.b         = 32'd2;
      bus.out_ready = 1'b1;

      repeat (3) begin
         @(negedge clk);
         chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
         chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
         chk("rst_outputs", {27'd0, bus.alu_result, bus.carry,
                             bus.over_flow, bus.zero, bus.illegal},
             64'd0);
      end
      @(posedge clk);
      #1;
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1;

      issue(4'd0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 1, 0, 0, 1, 1);
      issue(4'd0, 32'hFFFFFFFF, 32'h1, 32'h0, 1, 0, 1, 0, 1, 1);
      issue(4'd1, 32'd3, 32'd5, 32'hFFFFFFFE, 0, 0, 0, 0, 1, 1);
      issue(4'd1, 32'd5, 32'd5, 32'h0, 1, 0, 1, 0, 1, 1);
      issue(4'd2, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000,
            0, 0, 0, 0, 1, 1);
      issue(4'd3, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0,
            0, 0, 0, 0, 1, 1);
      issue(4'd4, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0,
            0, 0, 0, 0, 1, 1);
      issue(4'd8, 32'h80000000, 32'h24, 32'hF8000000, 0, 0, 0, 0, 1, 1);
      issue(4'd6, 32'h1, 32'd31, 32'h80000000, 0, 0, 0, 0, 1, 1);
      issue(4'd7, 32'h80000000, 32'd31, 32'h1, 0, 0, 0, 0, 1, 1);
      issue(4'd5, 32'hFFFFFFFF, 32'h1, 32'h1, 0, 0, 0, 0, 1, 1);
      issue(4'd9, 32'hFFFFFFFF, 32'h1, 32'h0, 0, 0, 1, 0, 1, 1);
      issue(4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 0, 0, 0, 0, 33, 1);
      issue(4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE,
            0, 0, 0, 0, 33, 1);
      issue(4'd10, 32'd123, 32'd456, 32'h0000DB18, 0, 0, 0, 0, 33, 1);
      issue(4'd12, 32'd100, 32'd7, 32'd14, 0, 0, 0, 0, 33, 1);
      issue(4'd13, 32'd100, 32'd7, 32'd2, 0, 0, 0, 0, 33, 1);
      issue(4'd12, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 0, 0, 0, 0, 33, 1);
      issue(4'd13, 32'hFFFFFFFF, 32'h10, 32'hF, 0, 0, 0, 0, 33, 1);
      issue(4'd12, 32'hDEADBEEF, 32'h0, 32'hFFFFFFFF, 0, 0, 0, 0, 33, 1);
      issue(4'd13, 32'h1234, 32'h0, 32'h1234, 0, 0, 0, 0, 33, 1);
      issue(4'd15, 32'h5, 32'h6, 32'h0, 0, 0, 1, 1, 1, 1);

      // Abort a DIVU mid-iteration: nothing may come out.
      issue(4'd12, 32'd1000, 32'd3, 32'd0, 0, 0, 0, 0, 33, 0);
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("abort_in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      vseen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (bus.out_valid) vseen = 1'b1;
      end
      chk("abort_no_valid", 64'(vseen), 64'd0);
      chk("abort_idle", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1;

      // Illegal opcode under backpressure.
      bus.out_ready = 1'b0;
      issue(4'd14, 32'hAAAA5555, 32'h1234, 32'h0, 0, 0, 1, 1, 1, 1);
      repeat (5) begin
         @(negedge clk);
         chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
         @(posedge clk);
         #1;
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("handoff_in_ready", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
      chk("post_handoff_ready", 64'(bus.in_ready), 64'd1);
      chk("post_handoff_valid", 64'(bus.out_valid), 64'd0);
      @(posedge clk);
      #1;

      issue(4'd0, 32'd2, 32'd3, 32'd5, 0, 0, 0, 0, 1, 1);

      for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
      chk("drain", 64'(sb.size()), 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end
endmodule
